mchan_tid_allocator: RTL and testbench

Transfer-ID allocator and completion tracker for the MCHAN control unit.
- Hands out free transfer IDs (SIDs) to enqueued commands.
- Follows each ID through the per-ID synchronization units, which sit directly downstream of the command queue and report back via `trans_registered`, `trans_status` and `term_sig`.
- Pulses a completion event to the core that owns the transfer.
- Returns the ID to the free pool when software releases it.

---
 rtl/mchan_tid_pkg.sv | 14 +
 rtl/tid_prio_enc.sv | 23 ++
 rtl/mchan_tid_allocator.sv | 116 +++++++++++
 tb/tb_mchan_tid_allocator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mchan_tid_pkg.sv
// Shared types and default sizing for the MCHAN transfer-ID allocator.
package mchan_tid_pkg;

  localparam int unsigned NB_TRANSFERS_DEF = 16;
  localparam int unsigned NB_CORES_DEF     = 8;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    ALLOC  = 2'b01,
    ACTIVE = 2'b10,
    DONE   = 2'b11
  } tid_state_e;

endpackage

// File: rtl/tid_prio_enc.sv
// Lowest-index-set-bit encoder; valid_o is low when no request bit is set.
module tid_prio_enc #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mchan_tid_allocator.sv
// Transfer-ID allocator: grants free IDs, tracks them through the synch units,
// pulses completion events to the owning core and recycles released IDs.
module mchan_tid_allocator
  import mchan_tid_pkg::*;
#(
  parameter int unsigned NB_TRANSFERS    = NB_TRANSFERS_DEF,
  parameter int unsigned NB_CORES        = NB_CORES_DEF,
  parameter int unsigned TRANS_SID_WIDTH = $clog2(NB_TRANSFERS),
  parameter int unsigned CORE_ID_WIDTH   = $clog2(NB_CORES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alloc_req_i,
  input  logic [CORE_ID_WIDTH-1:0]   alloc_core_i,
  output logic                       alloc_gnt_o,
  output logic [TRANS_SID_WIDTH-1:0] alloc_sid_o,
  output logic                       full_o,
  input  logic                       free_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] free_sid_i,
  input  logic [NB_TRANSFERS-1:0]    trans_registered_i,
  input  logic [NB_TRANSFERS-1:0]    trans_status_i,
  input  logic [NB_TRANSFERS-1:0]    term_sig_i,
  output logic [NB_TRANSFERS-1:0]    status_o,
  output logic [NB_CORES-1:0]        event_o,
  output logic                       error_o
);

  logic [NB_TRANSFERS-1:0]    w_free;
  logic [NB_TRANSFERS-1:0]    w_busy;
  logic [NB_TRANSFERS-1:0]    w_done_set;
  logic [NB_TRANSFERS-1:0]    w_bad_rel;
  logic [CORE_ID_WIDTH-1:0]   w_owner [NB_TRANSFERS];
  logic [TRANS_SID_WIDTH-1:0] w_sid;
  logic                       w_valid;
  logic [NB_CORES-1:0]        w_event;
  logic [NB_CORES-1:0]        r_event;
  logic                       r_error;

  tid_prio_enc #(
    .N (NB_TRANSFERS),
    .W (TRANS_SID_WIDTH)
  ) u_prio_enc (
    .req_i   (w_free),
    .idx_o   (w_sid),
    .valid_o (w_valid)
  );

  // A released ID is still DONE in its release cycle, so it cannot be granted then.
  assign full_o      = ~w_valid;
  assign alloc_gnt_o = alloc_req_i & w_valid;
  assign alloc_sid_o = w_sid;

  for (genvar g = 0; g < NB_TRANSFERS; g++) begin : g_tid
    tid_state_e               r_state;
    tid_state_e               w_state_nxt;
    logic [CORE_ID_WIDTH-1:0] r_owner;
    logic                     w_grant;
    logic                     w_release;

    assign w_grant   = alloc_gnt_o && (w_sid == TRANS_SID_WIDTH'(g));
    assign w_release = free_req_i && (free_sid_i == TRANS_SID_WIDTH'(g));

    // Termination wins over registration so zero-length transfers complete.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        FREE:    if (w_grant) w_state_nxt = ALLOC;
        ALLOC: begin
          if (term_sig_i[g])              w_state_nxt = DONE;
          else if (trans_registered_i[g]) w_state_nxt = ACTIVE;
        end
        ACTIVE:  if (term_sig_i[g]) w_state_nxt = DONE;
        DONE:    if (w_release) w_state_nxt = FREE;
        default: w_state_nxt = FREE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state <= FREE;
        r_owner <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (w_grant) r_owner <= alloc_core_i;
      end
    end

    assign w_free[g]     = (r_state == FREE);
    assign w_busy[g]     = (r_state == ALLOC) || (r_state == ACTIVE);
    assign w_done_set[g] = (r_state != DONE) && (w_state_nxt == DONE);
    assign w_bad_rel[g]  = w_release && (r_state != DONE);
    assign w_owner[g]    = r_owner;
  end

  always_comb begin
    w_event = '0;
    for (int i = 0; i < NB_TRANSFERS; i++) begin
      if (w_done_set[i]) w_event[w_owner[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_event <= '0;
      r_error <= 1'b0;
    end else begin
      r_event <= w_event;
      r_error <= |w_bad_rel;
    end
  end

  assign status_o = w_busy | trans_status_i;
  assign event_o  = r_event;
  assign error_o  = r_error;

endmodule

// File: tb/tb_mchan_tid_allocator.sv
// Scoreboard bench: driver updates a reference model and queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mchan_tid_allocator;

  localparam int unsigned NT = 16;
  localparam int unsigned NC = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 3;
  localparam int S_FREE = 0, S_ALLOC = 1, S_ACTIVE = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_req = 1'b0;
  logic [CW-1:0] alloc_core = '0;
  logic          free_req = 1'b0;
  logic [SW-1:0] free_sid = '0;
  logic [NT-1:0] trans_reg = '0;
  logic [NT-1:0] trans_stat = '0;
  logic [NT-1:0] term_sig = '0;
  logic          alloc_gnt;
  logic [SW-1:0] alloc_sid;
  logic          full;
  logic [NT-1:0] status;
  logic [NC-1:0] event_v;
  logic          error_v;

  always #5 clk = ~clk;

  mchan_tid_allocator dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .alloc_req_i        (alloc_req),
    .alloc_core_i       (alloc_core),
    .alloc_gnt_o        (alloc_gnt),
    .alloc_sid_o        (alloc_sid),
    .full_o             (full),
    .free_req_i         (free_req),
    .free_sid_i         (free_sid),
    .trans_registered_i (trans_reg),
    .trans_status_i     (trans_stat),
    .term_sig_i         (term_sig),
    .status_o           (status),
    .event_o            (event_v),
    .error_o            (error_v)
  );

  typedef struct { logic gnt; logic [SW-1:0] sid; } gnt_rec_t;
  typedef struct { logic [NT-1:0] st; logic full; } st_rec_t;
  typedef struct { int cyc; logic [NC-1:0] v; } pulse_rec_t;

  gnt_rec_t   gq[$];
  st_rec_t    sq[$];
  pulse_rec_t evq[$];
  pulse_rec_t erq[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit started = 0;
  int m_state[NT];
  int m_owner[NT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every cycle presents status/full/event/error; grants only when requested.
  always @(negedge clk) begin
    st_rec_t    s;
    gnt_rec_t   g;
    pulse_rec_t p;
    logic [NC-1:0] ev_exp;
    logic          er_exp;
    if (started) begin
      if (sq.size() == 0) chk("status_record_present", 0, 1);
      else begin
        s = sq.pop_front();
        chk("status", 32'(status), 32'(s.st));
        chk("full", 32'(full), 32'(s.full));
      end
      if (alloc_req) begin
        if (gq.size() == 0) chk("grant_record_present", 0, 1);
        else begin
          g = gq.pop_front();
          chk("alloc_gnt", 32'(alloc_gnt), 32'(g.gnt));
          if (g.gnt) chk("alloc_sid", 32'(alloc_sid), 32'(g.sid));
        end
      end
      ev_exp = '0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin p = evq.pop_front(); ev_exp = p.v; end
      chk("event", 32'(event_v), 32'(ev_exp));
      er_exp = 1'b0;
      if (erq.size() > 0 && erq[0].cyc == cyc) begin p = erq.pop_front(); er_exp = 1'b1; end
      chk("error", 32'(error_v), 32'(er_exp));
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin m_state[i] = S_FREE; m_owner[i] = 0; end
    evq.delete();
    erq.delete();
  endtask

  task automatic do_reset();
    st_rec_t s;
    s.st = '0;
    s.full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      rst = 1'b1; started = 1'b1;
      alloc_req = 0; free_req = 0; trans_reg = '0; term_sig = '0; trans_stat = '0;
      model_clear();
      sq.push_back(s);
    end
  endtask

  // One clock of stimulus; the model derives this cycle's outputs and next-cycle pulses.
  task automatic step(input logic req, input logic [CW-1:0] core, input logic freq,
                      input logic [SW-1:0] fsid, input logic [NT-1:0] reg_v,
                      input logic [NT-1:0] term_v, input logic [NT-1:0] ts_v);
    int lo;
    logic gnt;
    logic [NC-1:0] ev;
    st_rec_t s;
    gnt_rec_t g;
    pulse_rec_t p;
    @(posedge clk); #1;
    rst = 1'b0;
    alloc_req = req; alloc_core = core; free_req = freq; free_sid = fsid;
    trans_reg = reg_v; term_sig = term_v; trans_stat = ts_v;
    lo = -1;
    for (int i = NT - 1; i >= 0; i--) if (m_state[i] == S_FREE) lo = i;
    gnt = req && (lo >= 0);
    s.st = ts_v;
    for (int i = 0; i < NT; i++) if (m_state[i] == S_ALLOC || m_state[i] == S_ACTIVE) s.st[i] = 1'b1;
    s.full = (lo < 0);
    sq.push_back(s);
    if (req) begin g.gnt = gnt; g.sid = gnt ? SW'(lo) : '0; gq.push_back(g); end
    if (freq && m_state[fsid] != S_DONE) begin p.cyc = cyc + 1; p.v = '1; erq.push_back(p); end
    ev = '0;
    for (int i = 0; i < NT; i++) begin
      if (m_state[i] == S_FREE && gnt && lo == i) begin
        m_state[i] = S_ALLOC; m_owner[i] = int'(core);
      end else if ((m_state[i] == S_ALLOC || m_state[i] == S_ACTIVE) && term_v[i]) begin
        m_state[i] = S_DONE; ev[m_owner[i]] = 1'b1;
      end else if (m_state[i] == S_ALLOC && reg_v[i]) begin
        m_state[i] = S_ACTIVE;
      end else if (m_state[i] == S_DONE && freq && fsid == SW'(i)) begin
        m_state[i] = S_FREE;
      end
    end
    if (ev != '0) begin p.cyc = cyc + 1; p.v = ev; evq.push_back(p); end
  endtask

  task automatic idle();               step(0, 0, 0, 0, '0, '0, '0);              endtask
  task automatic alloc(input int c);   step(1, CW'(c), 0, 0, '0, '0, '0);         endtask
  task automatic rel(input int sid);   step(0, 0, 1, SW'(sid), '0, '0, '0);       endtask
  task automatic regs(input logic [NT-1:0] r); step(0, 0, 0, 0, r, '0, '0);       endtask
  task automatic terms(input logic [NT-1:0] t); step(0, 0, 0, 0, '0, t, '0);      endtask

  initial begin
    int dsel;
    logic [SW-1:0] fs;
    model_clear();
    // Basic flow
    do_reset();
    alloc(3);
    regs(16'h0001);
    terms(16'h0001);
    idle();
    rel(0);
    alloc(2);
    // Fill, 17th request, recycle DONE sid 5
    do_reset();
    for (int i = 0; i < 16; i++) alloc(i % 8);
    alloc(7);
    step(0, 0, 0, 0, 16'h0020, 16'h0020, '0);
    idle();
    rel(5);
    alloc(4);
    // Simultaneous release and allocation on sid 2
    terms(16'h0004);
    idle();
    step(1, 5, 1, 2, '0, '0, '0);
    alloc(5);
    // Zero-length transfer on sid 1
    do_reset();
    alloc(0);
    alloc(6);
    step(0, 0, 0, 0, 16'h0002, 16'h0002, '0);
    idle();
    // Illegal releases, release+term on ACTIVE id, and two owners completing together
    do_reset();
    for (int i = 0; i < 7; i++) alloc(i);
    regs(16'h007F);
    rel(4);
    idle();
    rel(9);
    step(0, 0, 1, 3, '0, 16'h0008, '0);
    terms(16'h0042);
    idle();
    terms(16'h0042);
    step(0, 0, 0, 0, '0, '0, 16'h8001);
    // Reset mid-operation with three active IDs
    do_reset();
    alloc(1); alloc(2); alloc(3);
    regs(16'h0007);
    do_reset();
    alloc(4);
    // Randomized traffic with occasional reset
    for (int n = 0; n < 1200; n++) begin
      if (n % 300 == 299) do_reset();
      dsel = -1;
      for (int i = 0; i < NT; i++) if (m_state[i] == S_DONE && ($urandom_range(0, 2) == 0 || dsel < 0)) dsel = i;
      fs = (dsel >= 0 && $urandom_range(0, 9) < 8) ? SW'(dsel) : SW'($urandom_range(0, NT - 1));
      step($urandom_range(0, 1) == 1, CW'($urandom_range(0, NC - 1)), $urandom_range(0, 2) == 0, fs,
           NT'($urandom & $urandom), NT'($urandom & $urandom & $urandom),
           NT'($urandom & $urandom & $urandom));
    end
    idle();
    idle();
    @(negedge clk); #1;
    chk("event_queue_drained", 32'(evq.size()), 0);
    chk("error_queue_drained", 32'(erq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
